// File: rtl/fu_writeback_arbiter.sv
// Purpose : shares the single ROB writeback port between the ALU and LS units; each side has a small result FIFO.
// Latency : 1 cycle from in_x_done to out_rob_done when the pipe is empty and unstalled (FIFO-head or same-cycle bypass).
// Backpres: in_rob_stall freezes the output register; FIFOs keep accepting until full, then out_x_ready drops.
//
// Ports:
//   in_clk, in_rst_n (async active-low), in_flush (sync clear of all pending results)
//   in_alu_* / out_alu_ready : ALU result input and FIFO readiness
//   in_ls_*  / out_ls_ready  : load/store result input and FIFO readiness
//   in_rob_stall             : ROB cannot take a writeback this cycle
//   out_rob_*                : registered writeback to the ROB (src 0 = ALU, 1 = LS)
//   out_error                : sticky flag, set when a result arrives while its FIFO is full
module fu_writeback_arbiter #(
    parameter int GPR_SIZE     = 64,
    parameter int ROB_IDX_SIZE = 4,
    parameter int QUEUE_DEPTH  = 2
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_flush,
    input  logic                    in_alu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_alu_dst_rob_index,
    input  logic [GPR_SIZE-1:0]     in_alu_value,
    input  logic                    in_alu_set_nzcv,
    input  logic [3:0]              in_alu_nzcv,
    input  logic                    in_alu_condition,
    output logic                    out_alu_ready,
    input  logic                    in_ls_done,
    input  logic [ROB_IDX_SIZE-1:0] in_ls_dst_rob_index,
    input  logic [GPR_SIZE-1:0]     in_ls_value,
    output logic                    out_ls_ready,
    input  logic                    in_rob_stall,
    output logic                    out_rob_done,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_set_nzcv,
    output logic [3:0]              out_rob_nzcv,
    output logic                    out_rob_condition,
    output logic                    out_rob_src,
    output logic                    out_error
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // ALU FIFO storage and control
    logic [ROB_IDX_SIZE-1:0] alu_q_dst  [QUEUE_DEPTH];
    logic [GPR_SIZE-1:0]     alu_q_val  [QUEUE_DEPTH];
    logic                    alu_q_set  [QUEUE_DEPTH];
    logic [3:0]              alu_q_nzcv [QUEUE_DEPTH];
    logic                    alu_q_cond [QUEUE_DEPTH];
    logic [PTR_W-1:0]        alu_wr_ptr, alu_rd_ptr;
    logic [CNT_W-1:0]        alu_cnt;

    // LS FIFO storage and control (flags are implicitly zero for loads)
    logic [ROB_IDX_SIZE-1:0] ls_q_dst [QUEUE_DEPTH];
    logic [GPR_SIZE-1:0]     ls_q_val [QUEUE_DEPTH];
    logic [PTR_W-1:0]        ls_wr_ptr, ls_rd_ptr;
    logic [CNT_W-1:0]        ls_cnt;

    // 1 = LS was granted last, so the ALU wins the next tie
    logic last_grant_ls;

    logic alu_acc, ls_acc;
    logic alu_head_vld, ls_head_vld;
    logic alu_cand, ls_cand;
    logic tie, grant_alu, grant_ls;
    logic out_load;
    logic alu_deq, ls_deq, alu_byp, ls_byp, alu_enq, ls_enq;

    assign out_alu_ready = (alu_cnt < DEPTH_C);
    assign out_ls_ready  = (ls_cnt  < DEPTH_C);

    // Anything presented during a flush is discarded outright.
    assign alu_acc = in_alu_done & out_alu_ready & ~in_flush;
    assign ls_acc  = in_ls_done  & out_ls_ready  & ~in_flush;

    assign alu_head_vld = (alu_cnt != '0);
    assign ls_head_vld  = (ls_cnt  != '0);

    // A queued head always takes precedence over a new result so per-unit order holds.
    assign alu_cand = alu_head_vld | alu_acc;
    assign ls_cand  = ls_head_vld  | ls_acc;

    assign tie       = alu_cand & ls_cand;
    assign grant_alu = alu_cand & (~ls_cand | last_grant_ls);
    assign grant_ls  = ls_cand & ~grant_alu;

    // Output register takes a new entry when empty or being drained this cycle.
    assign out_load = ~out_rob_done | ~in_rob_stall;

    assign alu_deq = out_load & grant_alu & alu_head_vld;
    assign ls_deq  = out_load & grant_ls  & ls_head_vld;
    assign alu_byp = out_load & grant_alu & ~alu_head_vld;
    assign ls_byp  = out_load & grant_ls  & ~ls_head_vld;
    // An accepted result goes to its FIFO unless it went straight to the output.
    assign alu_enq = alu_acc & ~alu_byp;
    assign ls_enq  = ls_acc  & ~ls_byp;

    // FIFO payload storage: no reset needed, validity lives in the counts.
    always_ff @(posedge in_clk) begin
        if (alu_enq) begin
            alu_q_dst[alu_wr_ptr]  <= in_alu_dst_rob_index;
            alu_q_val[alu_wr_ptr]  <= in_alu_value;
            alu_q_set[alu_wr_ptr]  <= in_alu_set_nzcv;
            alu_q_nzcv[alu_wr_ptr] <= in_alu_nzcv;
            alu_q_cond[alu_wr_ptr] <= in_alu_condition;
        end
        if (ls_enq) begin
            ls_q_dst[ls_wr_ptr] <= in_ls_dst_rob_index;
            ls_q_val[ls_wr_ptr] <= in_ls_value;
        end
    end

    // FIFO pointers and counts
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
            ls_wr_ptr  <= '0;
            ls_rd_ptr  <= '0;
            ls_cnt     <= '0;
        end else if (in_flush) begin
            alu_wr_ptr <= '0;
            alu_rd_ptr <= '0;
            alu_cnt    <= '0;
            ls_wr_ptr  <= '0;
            ls_rd_ptr  <= '0;
            ls_cnt     <= '0;
        end else begin
            if (alu_enq) alu_wr_ptr <= alu_wr_ptr + PTR_ONE;
            if (alu_deq) alu_rd_ptr <= alu_rd_ptr + PTR_ONE;
            case ({alu_enq, alu_deq})
                2'b10:   alu_cnt <= alu_cnt + CNT_W'(1);
                2'b01:   alu_cnt <= alu_cnt - CNT_W'(1);
                default: alu_cnt <= alu_cnt;
            endcase
            if (ls_enq) ls_wr_ptr <= ls_wr_ptr + PTR_ONE;
            if (ls_deq) ls_rd_ptr <= ls_rd_ptr + PTR_ONE;
            case ({ls_enq, ls_deq})
                2'b10:   ls_cnt <= ls_cnt + CNT_W'(1);
                2'b01:   ls_cnt <= ls_cnt - CNT_W'(1);
                default: ls_cnt <= ls_cnt;
            endcase
        end
    end

    // Registered writeback stage and round-robin state
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_rob_done          <= 1'b0;
            out_rob_dst_rob_index <= '0;
            out_rob_value         <= '0;
            out_rob_set_nzcv      <= 1'b0;
            out_rob_nzcv          <= 4'b0;
            out_rob_condition     <= 1'b0;
            out_rob_src           <= 1'b0;
            last_grant_ls         <= 1'b1;
        end else if (in_flush) begin
            out_rob_done          <= 1'b0;
            out_rob_dst_rob_index <= '0;
            out_rob_value         <= '0;
            out_rob_set_nzcv      <= 1'b0;
            out_rob_nzcv          <= 4'b0;
            out_rob_condition     <= 1'b0;
            out_rob_src           <= 1'b0;
            last_grant_ls         <= 1'b1;
        end else if (out_load) begin
            if (grant_alu) begin
                out_rob_done          <= 1'b1;
                out_rob_dst_rob_index <= alu_head_vld ? alu_q_dst[alu_rd_ptr]  : in_alu_dst_rob_index;
                out_rob_value         <= alu_head_vld ? alu_q_val[alu_rd_ptr]  : in_alu_value;
                out_rob_set_nzcv      <= alu_head_vld ? alu_q_set[alu_rd_ptr]  : in_alu_set_nzcv;
                out_rob_nzcv          <= alu_head_vld ? alu_q_nzcv[alu_rd_ptr] : in_alu_nzcv;
                out_rob_condition     <= alu_head_vld ? alu_q_cond[alu_rd_ptr] : in_alu_condition;
                out_rob_src           <= 1'b0;
                if (tie) last_grant_ls <= 1'b0;
            end else if (grant_ls) begin
                out_rob_done          <= 1'b1;
                out_rob_dst_rob_index <= ls_head_vld ? ls_q_dst[ls_rd_ptr] : in_ls_dst_rob_index;
                out_rob_value         <= ls_head_vld ? ls_q_val[ls_rd_ptr] : in_ls_value;
                out_rob_set_nzcv      <= 1'b0;
                out_rob_nzcv          <= 4'b0;
                out_rob_condition     <= 1'b0;
                out_rob_src           <= 1'b1;
                if (tie) last_grant_ls <= 1'b1;
            end else begin
                out_rob_done <= 1'b0;
            end
        end
    end

    // Sticky overflow flag: a result offered to a full FIFO is lost.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_error <= 1'b0;
        end else if (!in_flush && ((in_alu_done && !out_alu_ready) || (in_ls_done && !out_ls_ready))) begin
            out_error <= 1'b1;
        end
    end

endmodule
